obi_bram_bridge: RTL and testbench

//   Bridges one core memory port (req/gnt/rvalid, as driven by riscv32i Dmem/Pmem/ins ports) to a

---
 rtl/obi_bram_bridge_if.sv | 22 ++
 rtl/obi_bram_bridge.sv | 138 +++++++++++++
 tb/tb_obi_bram_bridge.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/obi_bram_bridge_if.sv
// Core-side memory port of the BRAM bridge: req/gnt request channel plus
// the in-order rvalid/rdata response channel.
interface obi_bram_bridge_if;
  logic        req_i;
  logic [31:0] addr_i;
  logic        we_i;
  logic [3:0]  be_i;
  logic [31:0] wdata_i;
  logic        gnt_o;
  logic        rvalid_o;
  logic [31:0] rdata_o;

  modport master (
    output req_i, addr_i, we_i, be_i, wdata_i,
    input  gnt_o, rvalid_o, rdata_o
  );

  modport slave (
    input  req_i, addr_i, we_i, be_i, wdata_i,
    output gnt_o, rvalid_o, rdata_o
  );
endinterface

// File: rtl/obi_bram_bridge.sv
// Bridges a core req/gnt/rvalid memory port onto BRAM port B: address window
// decode, BRAM reset/busy start-up sequencing, fixed-latency in-order responses.
module obi_bram_bridge #(
  parameter logic [31:0] ADDR_BASE    = 32'h0000_2600,
  parameter int unsigned MEM_BYTES    = 6656,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RST_CYCLES   = 4,
  parameter logic [31:0] ERR_DATA     = 32'hDEAD_BEEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  obi_bram_bridge_if.slave         bus,
  output logic                     err_o,
  output logic                     ready_o,
  output logic                     bram_clkb,
  output logic                     bram_enb,
  output logic                     bram_rstb,
  output logic [3:0]               bram_web,
  output logic [31:0]              bram_addrb,
  output logic [31:0]              bram_dinb,
  input  logic                     bram_rstb_busy,
  input  logic [31:0]              bram_doutb
);

  typedef enum logic [1:0] {S_RST, S_WAIT, S_RUN} state_t;

  typedef struct packed {
    logic valid;
    logic err;
    logic we;
  } resp_t;

  localparam int unsigned CNT_W     = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  state_t          state_q, state_d;
  logic [CNT_W-1:0] rst_cnt_q;
  resp_t           pipe_q [READ_LATENCY];
  resp_t           resp_out;
  logic            err_q;
  logic [31:0]     off;
  logic            in_range;
  logic            gnt;

  assign bram_clkb = clk;

  // Unsigned subtraction: addresses below the base wrap to huge offsets and
  // fall out of range without a separate lower-bound compare.
  assign off      = bus.addr_i - ADDR_BASE;
  assign in_range = (off < MEM_LIMIT);
  assign gnt      = (state_q == S_RUN) && bus.req_i && !bram_rstb_busy;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_cnt_q <= '0;
    end else if (state_q == S_RST && rst_cnt_q != CNT_LAST) begin
      rst_cnt_q <= rst_cnt_q + 1'b1;
    end
  end

  // NOTE: every output of an always_comb gets a default first, so no path
  // leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    bram_rstb = 1'b0;
    ready_o   = 1'b0;
    unique case (state_q)
      S_RST: begin
        bram_rstb = 1'b1;
        if (rst_cnt_q == CNT_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!bram_rstb_busy) state_d = S_RUN;
      end
      S_RUN: begin
        ready_o = 1'b1;
      end
      default: state_d = S_RST;
    endcase
  end

  always_comb begin
    bram_enb   = 1'b0;
    bram_web   = 4'h0;
    bram_addrb = 32'h0;
    bram_dinb  = 32'h0;
    if (gnt && in_range) begin
      bram_enb   = 1'b1;
      bram_web   = bus.we_i ? bus.be_i : 4'h0;
      bram_addrb = off & ~32'h3;
      bram_dinb  = bus.wdata_i;
    end
  end

  // NOTE: the response pipeline is a handful of flops, so it is cleared on
  // reset; that is what flushes in-flight responses. A real RAM array would not be.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(READ_LATENCY); i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= '{valid: gnt, err: gnt && !in_range, we: bus.we_i};
      for (int i = 1; i < int'(READ_LATENCY); i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (gnt && !in_range) begin
      err_q <= 1'b1;
    end
  end

  assign resp_out     = pipe_q[READ_LATENCY-1];
  assign err_o        = err_q;
  assign bus.gnt_o    = gnt;
  assign bus.rvalid_o = resp_out.valid;

  always_comb begin
    bus.rdata_o = 32'h0;
    if (resp_out.valid) begin
      if (resp_out.err)      bus.rdata_o = ERR_DATA;
      else if (!resp_out.we) bus.rdata_o = bram_doutb;
    end
  end

endmodule

// File: tb/tb_obi_bram_bridge.sv
// Directed bench for obi_bram_bridge: start-up sequencing, writes/reads with
// byte enables, range errors, latency-2 streaming, busy stall and reset flush.
module tb_obi_bram_bridge;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  always #5 clk = ~clk;

  obi_bram_bridge_if bus1();
  obi_bram_bridge_if bus2();

  logic        err1, ready1, clkb1, enb1, rstb1;
  logic [3:0]  web1;
  logic [31:0] addrb1, dinb1, dout1;
  logic        err2, ready2, clkb2, enb2, rstb2;
  logic [3:0]  web2;
  logic [31:0] addrb2, dinb2, dout2, s1_2;

  obi_bram_bridge dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .err_o(err1), .ready_o(ready1), .bram_clkb(clkb1), .bram_enb(enb1),
    .bram_rstb(rstb1), .bram_web(web1), .bram_addrb(addrb1), .bram_dinb(dinb1),
    .bram_rstb_busy(busy), .bram_doutb(dout1)
  );

  obi_bram_bridge #(.READ_LATENCY(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(bus2),
    .err_o(err2), .ready_o(ready2), .bram_clkb(clkb2), .bram_enb(enb2),
    .bram_rstb(rstb2), .bram_web(web2), .bram_addrb(addrb2), .bram_dinb(dinb2),
    .bram_rstb_busy(busy), .bram_doutb(dout2)
  );

  // Behavioural BRAMs: latency 1 for dut1, latency 2 for dut2.
  logic [31:0] mem1 [0:1663];
  logic [31:0] mem2 [0:1663];

  always @(posedge clk) begin
    if (enb1) begin
      for (int b = 0; b < 4; b++)
        if (web1[b]) mem1[addrb1[12:2]][8*b +: 8] <= dinb1[8*b +: 8];
      if (web1 == 4'h0) dout1 <= mem1[addrb1[12:2]];
    end
  end

  always @(posedge clk) begin
    if (enb2 && web2 == 4'h0) s1_2 <= mem2[addrb2[12:2]];
    dout2 <= s1_2;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive1(input logic req, input logic we, input logic [3:0] be,
                        input logic [31:0] addr, input logic [31:0] wdata);
    bus1.req_i = req; bus1.we_i = we; bus1.be_i = be;
    bus1.addr_i = addr; bus1.wdata_i = wdata;
    #1;
  endtask

  task automatic drive2(input logic req, input logic [31:0] addr);
    bus2.req_i = req; bus2.we_i = 1'b0; bus2.be_i = 4'h0;
    bus2.addr_i = addr; bus2.wdata_i = 32'h0;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 1664; i++) begin
      mem1[i] = 32'h0;
      mem2[i] = 32'h0;
    end
    for (int i = 0; i < 4; i++) mem2[i] = 32'hA0A0_0000 + 32'(i * 17);
    dout1 = 32'h0; dout2 = 32'h0; s1_2 = 32'h0;

    // Start-up: reset held 3 cycles with a request pending.
    rst_n = 1'b0;
    busy  = 1'b1;
    drive1(1'b1, 1'b0, 4'hF, 32'h2604, 32'h0);
    drive2(1'b0, 32'h0);
    repeat (3) tick();
    check("rst_gnt",    {31'h0, bus1.gnt_o},    32'h0);
    check("rst_rvalid", {31'h0, bus1.rvalid_o}, 32'h0);
    check("rst_rdata",  bus1.rdata_o,           32'h0);
    check("rst_enb",    {31'h0, enb1},          32'h0);
    check("rst_web",    {28'h0, web1},          32'h0);
    check("rst_addrb",  addrb1,                 32'h0);
    check("rst_rstb",   {31'h0, rstb1},         32'h1);
    check("rst_ready",  {31'h0, ready1},        32'h0);
    check("rst_err",    {31'h0, err1},          32'h0);

    rst_n = 1'b1;
    for (int c = 0; c <= 6; c++) begin
      check($sformatf("startup_rstb_%0d", c),  {31'h0, rstb1},     {31'h0, c < 4});
      check($sformatf("startup_ready_%0d", c), {31'h0, ready1},    32'h0);
      check($sformatf("startup_gnt_%0d", c),   {31'h0, bus1.gnt_o}, 32'h0);
      if (c == 6) begin
        busy = 1'b0;
        drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      end
      tick();
    end
    check("run_ready1", {31'h0, ready1}, 32'h1);
    check("run_ready2", {31'h0, ready2}, 32'h1);
    check("run_rstb",   {31'h0, rstb1},  32'h0);

    // Full-word write then read-back.
    drive1(1'b1, 1'b1, 4'hF, 32'h2604, 32'hCAFE_F00D);
    check("wr_gnt",   {31'h0, bus1.gnt_o}, 32'h1);
    check("wr_enb",   {31'h0, enb1},       32'h1);
    check("wr_web",   {28'h0, web1},       32'hF);
    check("wr_addrb", addrb1,              32'h4);
    check("wr_dinb",  dinb1,               32'hCAFE_F00D);
    tick();
    drive1(1'b1, 1'b0, 4'hF, 32'h2604, 32'h0);
    check("wr_rvalid", {31'h0, bus1.rvalid_o}, 32'h1);
    check("wr_rdata",  bus1.rdata_o,           32'h0);
    check("rd_web",    {28'h0, web1},          32'h0);
    check("rd_enb",    {31'h0, enb1},          32'h1);
    tick();
    drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("rd_rvalid", {31'h0, bus1.rvalid_o}, 32'h1);
    check("rd_rdata",  bus1.rdata_o,           32'hCAFE_F00D);
    tick();
    check("idle_rvalid", {31'h0, bus1.rvalid_o}, 32'h0);

    // Byte-lane write.
    drive1(1'b1, 1'b1, 4'b0010, 32'h2604, 32'h0000_AB00);
    check("bwr_web", {28'h0, web1}, 32'h2);
    tick();
    drive1(1'b1, 1'b0, 4'hF, 32'h2604, 32'h0);
    tick();
    drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("brd_rdata", bus1.rdata_o, 32'hCAFE_AB0D);
    tick();

    // Out-of-range below and above the window, then the last in-range word.
    drive1(1'b1, 1'b0, 4'hF, 32'h25FC, 32'h0);
    check("lo_gnt", {31'h0, bus1.gnt_o}, 32'h1);
    check("lo_enb", {31'h0, enb1},       32'h0);
    check("lo_err_before", {31'h0, err1}, 32'h0);
    tick();
    drive1(1'b1, 1'b0, 4'hF, 32'h4000, 32'h0);
    check("lo_rvalid", {31'h0, bus1.rvalid_o}, 32'h1);
    check("lo_rdata",  bus1.rdata_o,           32'hDEAD_BEEF);
    check("lo_err",    {31'h0, err1},          32'h1);
    check("hi_enb",    {31'h0, enb1},          32'h0);
    tick();
    drive1(1'b1, 1'b0, 4'hF, 32'h3FFC, 32'h0);
    check("hi_rdata", bus1.rdata_o, 32'hDEAD_BEEF);
    check("top_enb",  {31'h0, enb1}, 32'h1);
    check("top_addrb", addrb1,       32'h19FC);
    tick();
    drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("top_rvalid", {31'h0, bus1.rvalid_o}, 32'h1);
    check("top_rdata",  bus1.rdata_o,           32'h0);
    check("err_sticky", {31'h0, err1},          32'h1);
    tick();
    check("err_sticky2", {31'h0, err1}, 32'h1);

    // Latency-2 streaming on dut2: four back-to-back reads.
    for (int i = 0; i < 6; i++) begin
      if (i < 4) begin
        drive2(1'b1, 32'h2600 + 32'(4 * i));
        check($sformatf("lat2_gnt_%0d", i), {31'h0, bus2.gnt_o}, 32'h1);
      end else begin
        drive2(1'b0, 32'h0);
      end
      check($sformatf("lat2_rvalid_%0d", i), {31'h0, bus2.rvalid_o}, {31'h0, i >= 2});
      if (i >= 2)
        check($sformatf("lat2_rdata_%0d", i), bus2.rdata_o, 32'hA0A0_0000 + 32'((i - 2) * 17));
      tick();
    end
    check("lat2_rvalid_end", {31'h0, bus2.rvalid_o}, 32'h0);

    // Busy stalls grants without leaving RUN.
    busy = 1'b1;
    drive1(1'b1, 1'b0, 4'hF, 32'h2608, 32'h0);
    check("busy_gnt", {31'h0, bus1.gnt_o}, 32'h0);
    check("busy_enb", {31'h0, enb1},       32'h0);
    tick();
    check("busy_gnt2",  {31'h0, bus1.gnt_o}, 32'h0);
    check("busy_ready", {31'h0, ready1},     32'h1);
    busy = 1'b0;
    #1;
    check("unbusy_gnt", {31'h0, bus1.gnt_o}, 32'h1);
    tick();
    drive1(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check("unbusy_rvalid", {31'h0, bus1.rvalid_o}, 32'h1);
    tick();

    // Reset with two reads in flight on dut2: nothing may emerge afterwards.
    drive2(1'b1, 32'h2600);
    tick();
    drive2(1'b1, 32'h2604);
    tick();
    drive2(1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    check("flush_rvalid_now", {31'h0, bus2.rvalid_o}, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      check($sformatf("flush_rvalid2_%0d", c), {31'h0, bus2.rvalid_o}, 32'h0);
      check($sformatf("flush_rvalid1_%0d", c), {31'h0, bus1.rvalid_o}, 32'h0);
      tick();
    end
    check("flush_err_clear", {31'h0, err1}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
